ysyx_23060332_lsu: RTL and testbench
====================================

YSYX_23060332_LSU -- requirements
Module: ysyx_23060332_lsu

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, max cycles waiting for mem_ack before abort.
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports from exu: req_valid in 1; req_wen in 1; req_ren in 1; req_addr in 32; req_wdata in 32; req_wmask in 8 (low 4 bits used); req_func3 in 3 (load sign/size).
REQ-005 SHALL have ports to exu/pipeline: req_ready out 1; resp_valid out 1; resp_rdata out 32 (extended load data); resp_err out 1; busy out 1.
REQ-006 SHALL have memory-side ports: mem_valid out 1; mem_we out 1; mem_addr out 32 (word-aligned); mem_wdata out 32 (lane-shifted); mem_wstrb out 4; mem_ack in 1; mem_rdata in 32.

Function
REQ-007 SHALL implement FSM IDLE -> REQ -> WAIT -> RESP -> IDLE.
REQ-008 SHALL assert req_ready only in IDLE; transfer occurs when req_valid && req_ready && (req_wen || req_ren).
REQ-009 SHALL ignore req_valid with neither wen nor ren: no state change, no resp_valid.
REQ-010 SHALL give store priority if req_wen and req_ren both set; load not performed.
REQ-011 SHALL register address, data, mask, func3 on transfer; later input changes have no effect.
REQ-012 SHALL in REQ drive mem_valid=1 for exactly one cycle, mem_addr={addr[31:2],2'b00}, mem_wstrb=wmask[3:0]<<addr[1:0], mem_wdata=wdata<<(8*addr[1:0]); then go WAIT.
REQ-013 SHALL in WAIT sample mem_ack each cycle; on ack capture mem_rdata and go RESP.
REQ-014 SHALL count WAIT cycles; at TIMEOUT_CYCLES without ack go RESP with resp_err=1, resp_rdata=0.
REQ-015 SHALL in RESP assert resp_valid for exactly one cycle; for loads resp_rdata = (mem_rdata >> 8*addr[1:0]) extended per func3: 000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero; other func3 -> as LW.
REQ-016 SHALL drive resp_rdata=0 for stores.
REQ-017 SHALL assert busy in REQ, WAIT, RESP; minimum latency transfer->resp_valid is 3 cycles (ack in first WAIT cycle).
REQ-018 SHALL ignore mem_ack outside WAIT.

Reset
REQ-019 SHALL on rst (asynchronous, any state, including mid-transaction) enter IDLE, clear counter and captured registers; outputs: req_ready=1, busy=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
REQ-020 SHALL not complete an aborted transaction after rst deasserts; late mem_ack ignored.

Configuration
REQ-021 SHALL, with YSYX_23060332_LSU_ALIGN_CHECK_EN defined, reject misaligned accesses (halfword addr[0]=1; word addr[1:0]!=0): skip REQ/WAIT, go straight to RESP with resp_err=1, no mem_valid.
REQ-022 SHALL, without the macro, perform misaligned accesses unchecked; lanes beyond byte 3 dropped.

Structure
REQ-023 SHALL place FSM state encodings and func3 load codes in ysyx_23060332_define.v.
REQ-024 SHALL implement lane shift and sign/zero extension in sub-module ysyx_23060332_lsu_align (combinational).

Verification
REQ-025 SW addr 0x80000010, wdata 0xDEADBEEF, wmask 0x0F, ack first WAIT cycle -> mem_addr 0x80000010, mem_wstrb 0xF, resp_valid 3 cycles after transfer, resp_rdata 0.
REQ-026 LB addr 0x80000003, mem_rdata 0x80FF1234 -> resp_rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-027 SH addr 0x80000002, wdata 0x0000ABCD, wmask 0x03 -> mem_wstrb 0xC, mem_wdata 0xABCD0000.
REQ-028 Load with no ack, TIMEOUT_CYCLES=4 -> resp_valid, resp_err=1, resp_rdata 0 after 4 WAIT cycles.
REQ-029 rst pulse in WAIT then ack -> IDLE, no resp_valid, req_ready=1.
REQ-030 With macro, LW addr 0x80000002 -> no mem_valid, resp_err=1; without macro -> mem_wstrb/mem_addr 0x80000000 access performed.

Source files
------------

// File: rtl/ysyx_23060332_define.sv
// Shared LSU definitions: FSM state encodings, load func3 codes and the size/alignment helper.
package ysyx_23060332_define;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // func3[1:0] encodes access size for both loads and stores.
    function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] off);
        logic res;
        res = 1'b0;
        if (func3[1:0] == 2'b01)
            res = off[0];
        else if (func3[1:0] == 2'b10)
            res = (off != 2'b00);
        return res;
    endfunction

endpackage

// File: rtl/ysyx_23060332_lsu_align.sv
// Byte-lane steering: store data/strobe shift and load data shift with sign/zero extension.
module ysyx_23060332_lsu_align
    import ysyx_23060332_define::*;
(
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wmask_i,
    input  logic [2:0]  func3_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    // Lanes pushed past byte 3 fall off the 4-bit strobe and 32-bit data.
    assign wstrb_o = wmask_i << off_i;
    assign wdata_o = wdata_i << {off_i, 3'b000};
    assign shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        rdata_o = shifted;
        case (func3_i)
            F3_LB:   rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  rdata_o = {24'd0, shifted[7:0]};
            F3_LHU:  rdata_o = {16'd0, shifted[15:0]};
            default: rdata_o = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_23060332_lsu.sv
// Single-outstanding load/store unit: IDLE -> REQ -> WAIT -> RESP with ack timeout.
// Define YSYX_23060332_LSU_ALIGN_CHECK_EN to reject misaligned halfword/word accesses.
module ysyx_23060332_lsu
    import ysyx_23060332_define::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_wen,
    input  logic        req_ren,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [7:0]  req_wmask,
    input  logic [2:0]  req_func3,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [2:0]  func3_q, func3_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        xfer;
    logic        misaligned;
    logic [31:0] wdata_sh;
    logic [3:0]  wstrb_sh;
    logic [31:0] rdata_ext;
    logic        unused_wmask_hi;

    assign unused_wmask_hi = ^req_wmask[7:4];
    assign xfer = req_valid && (state_q == ST_IDLE) && (req_wen || req_ren);

`ifdef YSYX_23060332_LSU_ALIGN_CHECK_EN
    assign misaligned = is_misaligned(req_func3, req_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        func3_d = func3_q;
        we_d    = we_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wmask_d = req_wmask[3:0];
                    func3_d = req_func3;
                    we_d    = req_wen;
                    err_d   = misaligned;
                    rdata_d = 32'd0;
                    cnt_d   = '0;
                    state_d = misaligned ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            func3_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            func3_q <= func3_d;
            we_q    <= we_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    ysyx_23060332_lsu_align u_align (
        .off_i   (addr_q[1:0]),
        .wdata_i (wdata_q),
        .wmask_i (wmask_q),
        .func3_i (func3_q),
        .rdata_i (rdata_q),
        .wdata_o (wdata_sh),
        .wstrb_o (wstrb_sh),
        .rdata_o (rdata_ext)
    );

    // Memory-side outputs are only live in REQ so they read as zero otherwise.
    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign mem_valid  = (state_q == ST_REQ);
    assign mem_we     = (state_q == ST_REQ) && we_q;
    assign mem_addr   = (state_q == ST_REQ) ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_wdata  = (state_q == ST_REQ) ? wdata_sh : 32'd0;
    assign mem_wstrb  = (state_q == ST_REQ) ? wstrb_sh : 4'd0;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = (state_q == ST_RESP) && err_q;
    assign resp_rdata = ((state_q == ST_RESP) && !we_q && !err_q) ? rdata_ext : 32'd0;

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Directed bench for ysyx_23060332_lsu with TIMEOUT_CYCLES=4.
module tb_ysyx_23060332_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_wen = 1'b0;
    logic        req_ren = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [7:0]  req_wmask = '0;
    logic [2:0]  req_func3 = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_vec = 0;
    int n_err = 0;

    ysyx_23060332_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_wen    (req_wen),
        .req_ren    (req_ren),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .req_func3  (req_func3),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy),
        .mem_valid  (mem_valid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic issue(input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [7:0] wmask, input logic [2:0] f3);
        req_valid = 1'b1;
        req_wen   = we;
        req_ren   = re;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        req_func3 = f3;
        tick();
        // Scramble inputs after transfer; captured values must be used.
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_ren   = 1'b0;
        req_addr  = 32'h5555_5557;
        req_wdata = ~wdata;
        req_wmask = 8'hFF;
        req_func3 = 3'b011;
    endtask

    task automatic run_xfer(input string tag, input logic we, input logic re,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [7:0] wmask, input logic [2:0] f3,
                            input logic [31:0] ack_rdata, input logic [31:0] exp_maddr,
                            input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                            input logic [31:0] exp_rdata);
        issue(we, re, addr, wdata, wmask, f3);
        check({tag, "_mem_valid"}, 32'(mem_valid), 32'd1);
        check({tag, "_mem_we"}, 32'(mem_we), 32'(we));
        check({tag, "_mem_addr"}, mem_addr, exp_maddr);
        check({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'(exp_wstrb));
        check({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        tick();
        check({tag, "_wait_mem_valid"}, 32'(mem_valid), 32'd0);
        check({tag, "_wait_resp_valid"}, 32'(resp_valid), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = ack_rdata;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0BAD_F00D;
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata, exp_rdata);
        tick();
        check({tag, "_resp_done"}, 32'(resp_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
        $display("txn %s: addr %h rdata %h", tag, addr, resp_rdata);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        tick();

        run_xfer("sw", 1'b1, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 3'b010,
                 32'h1111_2222, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'd0);
        run_xfer("lb", 1'b0, 1'b1, 32'h8000_0003, 32'd0, 8'h00, 3'b000,
                 32'h80FF_1234, 32'h8000_0000, 32'd0, 4'h0, 32'hFFFF_FF80);
        run_xfer("lbu", 1'b0, 1'b1, 32'h8000_0003, 32'd0, 8'h00, 3'b100,
                 32'h80FF_1234, 32'h8000_0000, 32'd0, 4'h0, 32'h0000_0080);
        run_xfer("sh", 1'b1, 1'b0, 32'h8000_0002, 32'h0000_ABCD, 8'h03, 3'b001,
                 32'd0, 32'h8000_0000, 32'hABCD_0000, 4'hC, 32'd0);
        run_xfer("lh", 1'b0, 1'b1, 32'h8000_0002, 32'd0, 8'h00, 3'b001,
                 32'h8001_1234, 32'h8000_0000, 32'd0, 4'h0, 32'hFFFF_8001);
        run_xfer("lhu", 1'b0, 1'b1, 32'h8000_0002, 32'd0, 8'h00, 3'b101,
                 32'h8001_1234, 32'h8000_0000, 32'd0, 4'h0, 32'h0000_8001);
        run_xfer("lw", 1'b0, 1'b1, 32'h8000_0008, 32'd0, 8'h00, 3'b010,
                 32'h1234_5678, 32'h8000_0008, 32'd0, 4'h0, 32'h1234_5678);
        run_xfer("f3_011", 1'b0, 1'b1, 32'h8000_000C, 32'd0, 8'h00, 3'b011,
                 32'h8765_4321, 32'h8000_000C, 32'd0, 4'h0, 32'h8765_4321);
        run_xfer("wen_ren", 1'b1, 1'b1, 32'h8000_0004, 32'h1122_3344, 8'h0F, 3'b010,
                 32'hFFFF_FFFF, 32'h8000_0004, 32'h1122_3344, 4'hF, 32'd0);

        // Valid with neither read nor write is not a transfer.
        req_valid = 1'b1;
        tick();
        check("noop_ready", 32'(req_ready), 32'd1);
        check("noop_busy", 32'(busy), 32'd0);
        req_valid = 1'b0;
        tick();
        check("noop_resp_valid", 32'(resp_valid), 32'd0);
        $display("txn noop: ignored");

        // Timeout: four WAIT cycles without ack.
        mem_rdata = 32'h1234_5678;
        issue(1'b0, 1'b1, 32'h8000_0020, 32'd0, 8'h00, 3'b010);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_wait_resp_valid", 32'(resp_valid), 32'd0);
            check("to_wait_busy", 32'(busy), 32'd1);
        end
        tick();
        check("to_resp_valid", 32'(resp_valid), 32'd1);
        check("to_resp_err", 32'(resp_err), 32'd1);
        check("to_resp_rdata", resp_rdata, 32'd0);
        tick();
        check("to_idle", 32'(req_ready), 32'd1);
        $display("txn timeout: err %0d", 1);

        // Reset pulse while waiting, then a late ack.
        issue(1'b0, 1'b1, 32'h8000_0030, 32'd0, 8'h00, 3'b010);
        tick();
        check("rstw_in_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rstw_ready", 32'(req_ready), 32'd1);
        check("rstw_busy", 32'(busy), 32'd0);
        check("rstw_mem_valid", 32'(mem_valid), 32'd0);
        #2;
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFE_BABE;
        tick();
        check("rstw_no_resp1", 32'(resp_valid), 32'd0);
        tick();
        check("rstw_no_resp2", 32'(resp_valid), 32'd0);
        check("rstw_ready2", 32'(req_ready), 32'd1);
        mem_ack = 1'b0;
        $display("txn reset_in_wait: aborted");

`ifdef YSYX_23060332_LSU_ALIGN_CHECK_EN
        issue(1'b0, 1'b1, 32'h8000_0002, 32'd0, 8'h0F, 3'b010);
        check("mis_mem_valid", 32'(mem_valid), 32'd0);
        check("mis_resp_valid", 32'(resp_valid), 32'd1);
        check("mis_resp_err", 32'(resp_err), 32'd1);
        check("mis_resp_rdata", resp_rdata, 32'd0);
        tick();
        check("mis_idle", 32'(req_ready), 32'd1);
        $display("txn misaligned_lw: rejected");
`else
        run_xfer("mis_lw", 1'b0, 1'b1, 32'h8000_0002, 32'd0, 8'h0F, 3'b010,
                 32'hAABB_CCDD, 32'h8000_0000, 32'd0, 4'hC, 32'h0000_AABB);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
